// File: rtl/measure_sequencer_if.sv
// Control and result port of the measurement sequencer.
// master: the requester / result consumer. slave: the sequencer itself.
interface measure_sequencer_if #(
  parameter int CNT_W  = 32,
  parameter int GATE_W = 32
);
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              busy;
  logic [CNT_W-1:0]  ref_cnt;
  logic [CNT_W-1:0]  sig_cnt;
  logic [CNT_W-1:0]  high_cnt;
  logic              err;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output start, gate_len, result_ready,
    input  busy, ref_cnt, sig_cnt, high_cnt, err, result_valid
  );

  modport slave (
    input  start, gate_len, result_ready,
    output busy, ref_cnt, sig_cnt, high_cnt, err, result_valid
  );
endinterface

// File: rtl/measure_sequencer.sv
// Gate sequencer for the frequency / duty-cycle meter. Synchronises sig_in,
// opens the window on a rising edge, keeps it open for at least gate_len
// reference clocks, closes it on the next rising edge and reports the
// reference-cycle, signal-period and high-time counts on a valid/ready port.
module measure_sequencer #(
  parameter int CNT_W       = 32,
  parameter int GATE_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 100_000_000
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                sig_in,
  measure_sequencer_if.slave  bus
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, ARM, GATE, CLOSE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s, rise;
  logic [GATE_W-1:0]      len_q, len_d;
  logic [GATE_W-1:0]      timer_q, timer_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [CNT_W-1:0]       ref_q, ref_d, sig_q, sig_d, high_q, high_d;
  logic                   err_q, err_d;
  logic [CNT_W:0]         ref_inc, high_inc, sig_inc;

  // Saturating increment; MSB of the result flags an increment lost at all-ones.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] v,
                                             input logic inc);
    if (inc && (v == '1)) return {1'b1, v};
    return {1'b0, v + CNT_W'(inc)};
  endfunction

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  // Synchroniser chain plus one extra delay for edge detection.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s;
    end
  end

  // State, counters, gate timer and timeout counter registers.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      timer_q <= '0;
      to_q    <= '0;
      ref_q   <= '0;
      sig_q   <= '0;
      high_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      to_q    <= to_d;
      ref_q   <= ref_d;
      sig_q   <= sig_d;
      high_q  <= high_d;
      err_q   <= err_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    timer_d  = timer_q;
    to_d     = to_q;
    ref_d    = ref_q;
    sig_d    = sig_q;
    high_d   = high_q;
    err_d    = err_q;
    ref_inc  = sat_add(ref_q, 1'b1);
    high_inc = sat_add(high_q, s);
    sig_inc  = sat_add(sig_q, rise);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // A zero length would never let the gate run; treat it as one cycle.
          len_d   = (bus.gate_len == '0) ? GATE_W'(1) : bus.gate_len;
          ref_d   = '0;
          sig_d   = '0;
          high_d  = '0;
          err_d   = 1'b0;
          to_d    = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (rise) begin
          // The opening edge cycle is the first cycle of the window.
          ref_d   = CNT_W'(1);
          high_d  = CNT_W'(1);
          sig_d   = '0;
          timer_d = len_q - GATE_W'(1);
          to_d    = '0;
          state_d = (len_q == GATE_W'(1)) ? CLOSE : GATE;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      GATE: begin
        ref_d   = ref_inc[CNT_W-1:0];
        high_d  = high_inc[CNT_W-1:0];
        sig_d   = sig_inc[CNT_W-1:0];
        err_d   = err_q | ref_inc[CNT_W] | high_inc[CNT_W] | sig_inc[CNT_W];
        timer_d = timer_q - GATE_W'(1);
        if (timer_q <= GATE_W'(1)) begin
          to_d    = '0;
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        if (rise) begin
          // Closing edge ends the window: it counts a period but no ref/high cycle.
          sig_d   = sig_inc[CNT_W-1:0];
          err_d   = err_q | sig_inc[CNT_W];
          state_d = DONE;
        end else begin
          ref_d  = ref_inc[CNT_W-1:0];
          high_d = high_inc[CNT_W-1:0];
          err_d  = err_q | ref_inc[CNT_W] | high_inc[CNT_W];
          to_d   = to_q + TO_W'(1);
          if (to_q == TO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy         = (state_q == ARM) || (state_q == GATE) || (state_q == CLOSE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.ref_cnt      = ref_q;
  assign bus.sig_cnt      = sig_q;
  assign bus.high_cnt     = high_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_measure_sequencer.sv
// Bench for measure_sequencer: periodic sig_in patterns with random phase,
// duty and gate length, checked against a window-arithmetic reference model.
module tb_measure_sequencer;
  localparam int CW   = 8;
  localparam int GW   = 16;
  localparam int SS   = 2;
  localparam int TMO  = 50;
  localparam int MAXC = (1 << CW) - 1;
  localparam int HLEN = 20000;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic sig_in  = 1'b0;

  measure_sequencer_if #(.CNT_W(CW), .GATE_W(GW)) bus ();

  measure_sequencer #(.CNT_W(CW), .GATE_W(GW), .SYNC_STAGES(SS), .TIMEOUT(TMO)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .sig_in  (sig_in),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // cyc = index of the next rising edge when read at a falling edge
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  bit sig_arr [0:HLEN-1];
  int n_pass = 0;
  int n_chk  = 0;
  int per = 10, hi = 5, ph = 0, mode = 1;

  // Advance to the next falling edge and drive sig_in for the following rising edge.
  task automatic tick();
    @(negedge sys_clk);
    if (mode == 1) sig_in = 1'b0;
    else           sig_in = (((cyc + ph) % per) < hi);
    if (cyc < HLEN) sig_arr[cyc] = sig_in;
  endtask

  // Synchronised signal as seen by the sequencer at rising edge j.
  function automatic int s_at(input int j);
    if (j - SS < 0 || j - SS >= HLEN) return 0;
    return int'(sig_arr[j - SS]);
  endfunction

  function automatic bit rise_at(input int j);
    return (s_at(j) == 1) && (s_at(j - 1) == 0);
  endfunction

  // Reference model: start accepted at edge p; window runs from the opening
  // rise o to the first rise at or after o+len (exclusive).
  task automatic model(input int p, input int L, output int e_ref, output int e_sig,
                       output int e_high, output bit e_err, output int e_vpos);
    int le, o, c, cend, lim;
    le = (L == 0) ? 1 : L;
    o = -1; c = -1;
    e_ref = 0; e_sig = 0; e_high = 0; e_err = 1'b1; e_vpos = p + TMO;
    for (int j = p + 1; j <= p + TMO; j++) if (o < 0 && rise_at(j)) o = j;
    if (o >= 0) begin
      e_err = 1'b0;
      lim = o + le + TMO - 1;
      for (int j = o + le; j <= lim; j++) if (c < 0 && rise_at(j)) c = j;
      if (c < 0) begin e_err = 1'b1; cend = lim + 1; e_vpos = lim; end
      else       begin cend = c; e_vpos = c; end
      e_ref = cend - o;
      for (int j = o; j < cend; j++) e_high += s_at(j);
      for (int j = o + 1; j <= e_vpos; j++) if (rise_at(j)) e_sig++;
      if (e_ref  > MAXC) begin e_ref  = MAXC; e_err = 1'b1; end
      if (e_high > MAXC) begin e_high = MAXC; e_err = 1'b1; end
      if (e_sig  > MAXC) begin e_sig  = MAXC; e_err = 1'b1; end
    end
  endtask

  // One measurement: start is raised immediately (caller is in IDLE at a falling edge).
  task automatic measure(input int L, input int rdy_delay, input bit poke,
                         output int p, output int vseen, output int o_ref, output int o_sig,
                         output int o_high, output bit o_err, output bit stable,
                         output bit busy_ok, output bit post_valid, output int post_ref);
    bus.start = 1'b1; bus.gate_len = GW'(L); p = cyc;
    tick();
    bus.start = 1'b0;
    busy_ok = bus.busy;
    vseen = -1;
    for (int k = 0; k < 3000; k++) begin
      if (bus.result_valid) begin vseen = cyc; break; end
      bus.start = poke ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick();
    end
    o_ref = int'(bus.ref_cnt); o_sig = int'(bus.sig_cnt);
    o_high = int'(bus.high_cnt); o_err = bus.err;
    stable = 1'b1;
    for (int k = 0; k < rdy_delay; k++) begin
      bus.start = poke ? ($urandom_range(0, 1) == 0) : 1'b0;
      tick();
      if (!bus.result_valid || int'(bus.ref_cnt) != o_ref || int'(bus.sig_cnt) != o_sig ||
          int'(bus.high_cnt) != o_high || bus.err != o_err) stable = 1'b0;
    end
    bus.start = 1'b0; bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    post_valid = bus.result_valid;
    post_ref = int'(bus.ref_cnt);
  endtask

  int p, vs, r, sg, h, er_i, vp, pr;
  bit e, st, bo, pv, ee;

  task automatic test_reset();
    rst_n = 1'b0; mode = 1;
    repeat (3) tick();
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.result_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.result_valid); else n_pass++;
    n_chk++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %0b want 0", bus.err); else n_pass++;
    n_chk++; if (bus.ref_cnt !== '0) $display("FAIL reset_ref: got %0d want 0", bus.ref_cnt); else n_pass++;
    n_chk++; if (bus.sig_cnt !== '0) $display("FAIL reset_sig: got %0d want 0", bus.sig_cnt); else n_pass++;
    n_chk++; if (bus.high_cnt !== '0) $display("FAIL reset_high: got %0d want 0", bus.high_cnt); else n_pass++;
    rst_n = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_spec_patterns();
    int er, es, eh, ev; bit eerr;
    // period 10, duty 30 %, gate 100
    mode = 0; per = 10; hi = 3; ph = $urandom_range(0, 9);
    repeat (4) tick();
    measure(100, 3, 1'b0, p, vs, r, sg, h, e, st, bo, pv, pr);
    n_chk++; if (bo !== 1'b1) $display("FAIL p10_busy_next: got %0b want 1", bo); else n_pass++;
    n_chk++; if (r != 100) $display("FAIL p10_ref: got %0d want 100", r); else n_pass++;
    n_chk++; if (sg != 10) $display("FAIL p10_sig: got %0d want 10", sg); else n_pass++;
    n_chk++; if (h != 30) $display("FAIL p10_high: got %0d want 30", h); else n_pass++;
    n_chk++; if (e !== 1'b0) $display("FAIL p10_err: got %0b want 0", e); else n_pass++;
    n_chk++; if (st !== 1'b1) $display("FAIL p10_hold: result not held stable while not ready"); else n_pass++;
    model(p, 100, er, es, eh, eerr, ev);
    n_chk++; if (vs != ev + 1) $display("FAIL p10_valid_time: got %0d want %0d", vs, ev + 1); else n_pass++;
    n_chk++; if (pv !== 1'b0) $display("FAIL p10_valid_drop: got %0b want 0", pv); else n_pass++;
    n_chk++; if (pr != 100) $display("FAIL p10_ref_kept: got %0d want 100", pr); else n_pass++;
    // period 7, gate 20: closes on the first edge after the gate
    per = 7; hi = $urandom_range(1, 6); ph = $urandom_range(0, 6);
    repeat (4) tick();
    measure(20, 0, 1'b0, p, vs, r, sg, h, e, st, bo, pv, pr);
    model(p, 20, er, es, eh, eerr, ev);
    n_chk++; if (r != 21) $display("FAIL p7_ref: got %0d want 21", r); else n_pass++;
    n_chk++; if (sg != 3) $display("FAIL p7_sig: got %0d want 3", sg); else n_pass++;
    n_chk++; if (h != eh) $display("FAIL p7_high: got %0d want %0d", h, eh); else n_pass++;
    // gate_len 0 behaves as 1
    per = 4; hi = 2; ph = $urandom_range(0, 3);
    repeat (4) tick();
    measure(0, 1, 1'b0, p, vs, r, sg, h, e, st, bo, pv, pr);
    n_chk++; if (r != 4) $display("FAIL len0_ref: got %0d want 4", r); else n_pass++;
    n_chk++; if (sg != 1) $display("FAIL len0_sig: got %0d want 1", sg); else n_pass++;
    n_chk++; if (h != 2) $display("FAIL len0_high: got %0d want 2", h); else n_pass++;
  endtask

  task automatic test_timeout();
    mode = 1;
    repeat (5) tick();
    measure(30, 2, 1'b0, p, vs, r, sg, h, e, st, bo, pv, pr);
    n_chk++; if (e !== 1'b1) $display("FAIL tmo_err: got %0b want 1", e); else n_pass++;
    n_chk++; if (r != 0 || sg != 0 || h != 0) $display("FAIL tmo_counts: got %0d/%0d/%0d want 0/0/0", r, sg, h); else n_pass++;
    // ARM entry is observed at p+1; valid must appear TIMEOUT cycles later
    n_chk++; if (vs - (p + 1) != TMO) $display("FAIL tmo_latency: got %0d want %0d", vs - (p + 1), TMO); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int er, es, eh, ev; bit eerr;
    mode = 0; per = 9; hi = 4; ph = $urandom_range(0, 8);
    repeat (4) tick();
    measure(40, 5, 1'b1, p, vs, r, sg, h, e, st, bo, pv, pr);
    model(p, 40, er, es, eh, eerr, ev);
    n_chk++; if (r != er || sg != es || h != eh || e != eerr)
      $display("FAIL start_ign_result: got %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b", r, sg, h, e, er, es, eh, eerr); else n_pass++;
    n_chk++; if (st !== 1'b1) $display("FAIL start_ign_hold: result changed in DONE"); else n_pass++;
    n_chk++; if (pv !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL start_ign_after: valid %0b busy %0b want 0/0", pv, bus.busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int er, es, eh, ev; bit eerr;
    mode = 0; per = 10; hi = 5; ph = $urandom_range(0, 9);
    repeat (4) tick();
    bus.start = 1'b1; bus.gate_len = GW'(100);
    tick();
    bus.start = 1'b0;
    repeat (30) tick();
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before: got %0b want 1", bus.busy); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_chk++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0)
      $display("FAIL mid_rst_ctrl: busy %0b valid %0b want 0/0", bus.busy, bus.result_valid); else n_pass++;
    n_chk++; if (bus.ref_cnt !== '0 || bus.sig_cnt !== '0 || bus.high_cnt !== '0)
      $display("FAIL mid_rst_counts: got %0d/%0d/%0d want 0/0/0", bus.ref_cnt, bus.sig_cnt, bus.high_cnt); else n_pass++;
    rst_n = 1'b1;
    repeat (6) tick();
    measure(25, 1, 1'b0, p, vs, r, sg, h, e, st, bo, pv, pr);
    model(p, 25, er, es, eh, eerr, ev);
    n_chk++; if (r != er || sg != es || h != eh || e != eerr)
      $display("FAIL mid_remeasure: got %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b", r, sg, h, e, er, es, eh, eerr); else n_pass++;
  endtask

  task automatic test_saturation();
    mode = 0; per = 10; hi = 3; ph = $urandom_range(0, 9);
    repeat (4) tick();
    measure(300, 0, 1'b0, p, vs, r, sg, h, e, st, bo, pv, pr);
    n_chk++; if (r != MAXC) $display("FAIL sat_ref: got %0d want %0d", r, MAXC); else n_pass++;
    n_chk++; if (e !== 1'b1) $display("FAIL sat_err: got %0b want 1", e); else n_pass++;
    n_chk++; if (sg != 30 || h != 90) $display("FAIL sat_other: got %0d/%0d want 30/90", sg, h); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int er, es, eh, ev; bit eerr;
    mode = 0; per = $urandom_range(3, 12); hi = $urandom_range(1, per - 1); ph = 0;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      measure($urandom_range(5, 40), 0, 1'b0, p, vs, r, sg, h, e, st, bo, pv, pr);
      model(p, int'(bus.gate_len), er, es, eh, eerr, ev);
      n_chk++; if (bo !== 1'b1) $display("FAIL b2b_accept%0d: busy %0b want 1", i, bo); else n_pass++;
      n_chk++; if (r != er || sg != es || h != eh || e != eerr || vs != ev + 1)
        $display("FAIL b2b_result%0d: got %0d/%0d/%0d/%0b@%0d want %0d/%0d/%0d/%0b@%0d",
                 i, r, sg, h, e, vs, er, es, eh, eerr, ev + 1); else n_pass++;
    end
  endtask

  task automatic test_random();
    int er, es, eh, ev, L; bit eerr;
    for (int i = 0; i < 15; i++) begin
      mode = 0; per = $urandom_range(2, 40); hi = $urandom_range(1, per - 1);
      ph = $urandom_range(0, per - 1); L = $urandom_range(0, 120);
      repeat ($urandom_range(1, 6)) tick();
      measure(L, $urandom_range(0, 4), 1'b0, p, vs, r, sg, h, e, st, bo, pv, pr);
      model(p, L, er, es, eh, eerr, ev);
      n_chk++; if (r != er) $display("FAIL rnd%0d_ref: got %0d want %0d", i, r, er); else n_pass++;
      n_chk++; if (sg != es) $display("FAIL rnd%0d_sig: got %0d want %0d", i, sg, es); else n_pass++;
      n_chk++; if (h != eh) $display("FAIL rnd%0d_high: got %0d want %0d", i, h, eh); else n_pass++;
      n_chk++; if (e != eerr) $display("FAIL rnd%0d_err: got %0b want %0b", i, e, eerr); else n_pass++;
      n_chk++; if (vs != ev + 1) $display("FAIL rnd%0d_valid_time: got %0d want %0d", i, vs, ev + 1); else n_pass++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.gate_len = '0;
    bus.result_ready = 1'b0;
    test_reset();
    test_spec_patterns();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/measure_sequencer.md
# measure_sequencer

Sequencing controller for the frequency/duty-cycle meter: on a start request it synchronises the measured signal, waits for a rising edge, holds a gate open for a programmed number of reference clocks, and closes it on the next signal rising edge. It counts reference cycles, signal periods and high-time cycles, then presents them on a valid/ready result port for the divider/display stage. It sits between the raw `sig_in` pin and the arithmetic that derives frequency and duty cycle.

## Interface
- `CNT_W`, 32: width of `ref_cnt`, `sig_cnt`, `high_cnt`.
- `GATE_W`, 32: width of `gate_len`.
- `SYNC_STAGES`, 2: flip-flop stages on `sig_in` (minimum 2).
- `TIMEOUT`, 100_000_000: cycles without a qualifying edge in ARM or CLOSE before abort.
- `sys_clk` in 1: single clock. Everything is rising-edge.
- `rst_n` in 1: synchronous, active-low reset.
- `sig_in` in 1: asynchronous measured signal.
- `start` in 1: one-cycle or level request. Honoured only in IDLE.
- `gate_len` in GATE_W: minimum gate length in `sys_clk` cycles. Sampled when `start` is accepted.
- `busy` out 1: high in ARM, GATE and CLOSE.
- `ref_cnt` out CNT_W: `sys_clk` cycles between the opening and closing edges.
- `sig_cnt` out CNT_W: number of complete signal periods in the window.
- `high_cnt` out CNT_W: cycles inside the window where the synchronised signal is high.
- `err` out 1: set on timeout or counter saturation. Valid with `result_valid`.
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts the result.

## Operation
- Synchroniser: `s` is the output of `SYNC_STAGES` flops. `s_d` is `s` delayed by one cycle. `rise = s & ~s_d`.
- States: IDLE, ARM, GATE, CLOSE, DONE.
- IDLE, on `start`:
  - latch `gate_len`; a value of 0 is treated as 1;
  - clear all counters, `err` and the timeout counter;
  - go to ARM.
- ARM, on `rise`:
  - `ref_cnt` = 1, `high_cnt` = 1, `sig_cnt` = 0;
  - gate timer = latched length − 1;
  - go to GATE.
- ARM, when the timeout counter reaches TIMEOUT−1 with no `rise`: `err` = 1, go to DONE. Counters remain 0.
- GATE, every cycle:
  - `ref_cnt` += 1, `high_cnt` += `s`;
  - on `rise`, `sig_cnt` += 1;
  - gate timer decrements; when it is 0, go to CLOSE.
  - A `rise` in the same cycle the timer reaches 0 still counts, and the next state is CLOSE.
  - If the gate timer is already 0 on entry (length 1), go directly to CLOSE.
- CLOSE, cycle without `rise`: `ref_cnt` += 1, `high_cnt` += `s`, timeout counter += 1.
- CLOSE, on `rise`:
  - `sig_cnt` += 1;
  - this cycle is NOT added to `ref_cnt` or `high_cnt`;
  - go to DONE.
- CLOSE timeout: the timeout counter is cleared on CLOSE entry. At TIMEOUT−1, set `err` = 1 and go to DONE with the partial counts.
- DONE:
  - `result_valid` = 1;
  - outputs are held stable;
  - `start` is ignored;
  - on `result_valid & result_ready`, go to IDLE.
- Saturation: any counter at all-ones stays at all-ones and sets `err`. The measurement continues.
- Derived quantities: f = `sig_cnt`·f_clk / `ref_cnt`; duty = `high_cnt` / `ref_cnt`. Both are computed downstream.

## Timing
- Reset values:
  - state IDLE;
  - `busy`, `result_valid`, `err` = 0;
  - `ref_cnt`, `sig_cnt`, `high_cnt` = 0;
  - synchroniser flops = 0.
- `start` sampled in cycle N gives `busy` = 1 in cycle N+1.
- An edge on `sig_in` appears as `rise` SYNC_STAGES+1 cycles later.
- Reported window = the cycle of the opening `rise` up to, but excluding, the cycle of the closing `rise`. Therefore `ref_cnt` ≥ latched gate length.
- `result_valid` rises in the cycle after the closing `rise` or the timeout.
- Handshake completes in the cycle where both `result_valid` and `result_ready` are high. `result_valid` is 0 in the next cycle, and a new `start` is accepted from that cycle.
- `result_ready` held high: minimum DONE residency is 1 cycle.
- Counter and result outputs are not cleared on leaving DONE. They change only on the next accepted `start`.
- `rst_n` low mid-measurement: all state returns to reset values at the next edge. No result is emitted.

## Test plan
- `sig_in` period 10 cycles, duty 30%, `gate_len` = 100, `start` pulse:
  - `ref_cnt` = 100, `sig_cnt` = 10, `high_cnt` = 30, `err` = 0;
  - `result_valid` held until `result_ready`.
- `sig_in` period 7, `gate_len` = 20: window closes on the first edge after the gate expires, giving `ref_cnt` = 21, `sig_cnt` = 3.
- `sig_in` held at 0 with `TIMEOUT` = 50: `result_valid` appears 50 cycles after ARM entry with `err` = 1 and all counters 0.
- `gate_len` = 0 with period 4: behaves as length 1, giving `ref_cnt` = 4, `sig_cnt` = 1.
- `start` asserted during GATE and during DONE: ignored, and the result is unchanged.
- `rst_n` asserted in the middle of GATE: the next cycle shows `busy` = 0, `result_valid` = 0 and counters 0; a following `start` then measures correctly.
